intr_req_gen: RTL and testbench

Peripheral-side interrupt requester that drives the core's two level-sensitive interrupt lines and completes the four-phase handshake against the core's registered acknowledge. Each channel counts single-cycle event pulses from a peripheral, raises its line while events are pending, and drops the line on acknowledge. It re-arms only after the acknowledge has been released. It sits between peripheral event sources and the core's interrupt acknowledge controller.

---
 rtl/intr_req_gen.sv | 47 ++++
 tb/tb_intr_req_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/intr_req_gen.sv
// intr_req_gen: two independent level-sensitive interrupt requesters with pending-event
// counters, four-phase handshake against a registered acknowledge, and sticky overflow.
module intr_req_gen #(
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         i_evt,
  input  logic [1:0]         i_en,
  input  logic [1:0]         i_int_ack,
  input  logic [1:0]         i_ovf_clr,
  output logic [1:0]         o_intr_h,
  output logic [2*CNT_W-1:0] o_pend_cnt,
  output logic [1:0]         o_ovf
);
  typedef enum logic [1:0] {IDLE, REQ, ACKED} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  for (genvar c = 0; c < 2; c++) begin : g_ch
    state_t           state, nxt;
    logic [CNT_W-1:0] cnt;
    logic             intr, ovf, inc, dec, lost;
    assign inc  = i_evt[c] & i_en[c];
    assign dec  = (state == IDLE) & i_en[c] & (cnt != '0);
    assign lost = inc & ~dec & (cnt == MAX);
    always_comb
      nxt = (state == IDLE && dec)             ? REQ   :
            (state == REQ && i_int_ack[c])     ? ACKED :
            (state == ACKED && !i_int_ack[c])  ? IDLE  : state;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        state <= IDLE;
        cnt   <= '0;
        intr  <= 1'b0;
        ovf   <= 1'b0;
      end else begin
        state <= nxt;
        intr  <= (nxt == REQ);
        cnt   <= (inc && !dec && cnt != MAX) ? cnt + 1'b1 :
                 (dec && !inc)               ? cnt - 1'b1 : cnt;
        // a lost event wins over a simultaneous clear
        ovf   <= lost | (ovf & ~i_ovf_clr[c]);
      end
    assign o_intr_h[c]                  = intr;
    assign o_ovf[c]                     = ovf;
    assign o_pend_cnt[c*CNT_W +: CNT_W] = cnt;
  end
endmodule

// File: tb/tb_intr_req_gen.sv
// tb_intr_req_gen: directed vectors against a counting/handshake model of intr_req_gen,
// compared every cycle, plus hand-computed literal checks.
module tb_intr_req_gen;
  localparam int CNT_W = 3;
  localparam int MAXC  = (1 << CNT_W) - 1;
  logic               clk = 0;
  logic               rst_n = 0;
  logic [1:0]         i_evt = 0, i_en = 0, i_int_ack = 0, i_ovf_clr = 0;
  logic [1:0]         o_intr_h, o_ovf;
  logic [2*CNT_W-1:0] o_pend_cnt;
  int vectors = 0, miscompares = 0;
  int m_phase [2];
  int m_cnt   [2];
  bit m_ovf   [2];

  intr_req_gen #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_evt(i_evt), .i_en(i_en), .i_int_ack(i_int_ack),
    .i_ovf_clr(i_ovf_clr), .o_intr_h(o_intr_h), .o_pend_cnt(o_pend_cnt), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  // model: phase 0 = quiet, 1 = line raised, 2 = waiting for ack release
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin m_phase[c] = 0; m_cnt[c] = 0; m_ovf[c] = 0; end
    end else begin
      for (int c = 0; c < 2; c++) begin
        int n, take;
        take = (m_phase[c] == 0 && i_en[c] && m_cnt[c] > 0) ? 1 : 0;
        n = m_cnt[c] + ((i_evt[c] && i_en[c]) ? 1 : 0) - take;
        if (n > MAXC) begin n = MAXC; m_ovf[c] = 1; end
        else if (i_ovf_clr[c]) m_ovf[c] = 0;
        m_cnt[c] = n;
        case (m_phase[c])
          0: if (take == 1) m_phase[c] = 1;
          1: if (i_int_ack[c]) m_phase[c] = 2;
          default: if (!i_int_ack[c]) m_phase[c] = 0;
        endcase
      end
    end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n)
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("model intr%0d", c), int'(o_intr_h[c]), (m_phase[c] == 1) ? 1 : 0);
        chk($sformatf("model cnt%0d", c), int'(o_pend_cnt[c*CNT_W +: CNT_W]), m_cnt[c]);
        chk($sformatf("model ovf%0d", c), int'(o_ovf[c]), int'(m_ovf[c]));
      end

  task automatic step(input logic [1:0] evt, en, ack, clr);
    i_evt = evt; i_en = en; i_int_ack = ack; i_ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_evt = 0; i_en = 0; i_int_ack = 0; i_ovf_clr = 0;
    #2 rst_n = 0;
    @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1;
  endtask

  function automatic int cnt_of(input int c);
    return int'(o_pend_cnt[c*CNT_W +: CNT_W]);
  endfunction

  int pulses;
  logic prev;

  initial begin
    do_reset();
    chk("reset intr", int'(o_intr_h), 0);
    chk("reset cnt", int'(o_pend_cnt), 0);
    chk("reset ovf", int'(o_ovf), 0);

    // single event on ch0
    step(2'b01, 2'b11, 2'b00, 2'b00);
    chk("single cnt0 after event", cnt_of(0), 1);
    chk("single intr not yet", int'(o_intr_h), 0);
    step(2'b00, 2'b11, 2'b00, 2'b00);
    chk("single intr raised", int'(o_intr_h), 1);
    chk("single cnt0 consumed", cnt_of(0), 0);
    step(2'b00, 2'b11, 2'b00, 2'b00);
    step(2'b00, 2'b11, 2'b01, 2'b00);
    chk("single ack drops line", int'(o_intr_h), 0);
    step(2'b00, 2'b11, 2'b00, 2'b00);
    step(2'b00, 2'b11, 2'b00, 2'b00);
    chk("single stays low", int'(o_intr_h), 0);

    // queue of three on ch1
    step(2'b10, 2'b11, 2'b00, 2'b00);
    step(2'b10, 2'b11, 2'b00, 2'b00);
    step(2'b10, 2'b11, 2'b00, 2'b00);
    chk("queue intr1 high", int'(o_intr_h), 2);
    chk("queue cnt1", cnt_of(1), 2);
    pulses = 1; prev = o_intr_h[1];
    for (int i = 0; i < 20; i++) begin
      step(2'b00, 2'b11, {o_intr_h[1], 1'b0}, 2'b00);
      if (o_intr_h[1] && !prev) pulses++;
      prev = o_intr_h[1];
    end
    chk("queue pulse count", pulses, 3);
    chk("queue cnt1 drained", cnt_of(1), 0);

    // saturation with ch0 parked in ACKED
    do_reset();
    for (int i = 0; i < 10; i++) step(2'b01, 2'b11, 2'b01, 2'b00);
    chk("sat cnt0", cnt_of(0), 7);
    chk("sat ovf", int'(o_ovf), 1);
    step(2'b01, 2'b11, 2'b01, 2'b01);
    chk("sat set wins over clear", int'(o_ovf), 1);
    step(2'b00, 2'b11, 2'b01, 2'b01);
    chk("sat clear", int'(o_ovf), 0);
    chk("sat cnt0 held", cnt_of(0), 7);

    // simultaneous events
    do_reset();
    step(2'b11, 2'b11, 2'b00, 2'b00);
    step(2'b00, 2'b11, 2'b00, 2'b00);
    chk("simul both lines", int'(o_intr_h), 3);
    step(2'b00, 2'b11, 2'b01, 2'b00);
    chk("simul ack ch0 only", int'(o_intr_h), 2);

    // enable gating
    do_reset();
    step(2'b11, 2'b00, 2'b00, 2'b00);
    step(2'b11, 2'b00, 2'b00, 2'b00);
    chk("gate no count", int'(o_pend_cnt), 0);
    chk("gate no ovf", int'(o_ovf), 0);
    step(2'b01, 2'b11, 2'b00, 2'b00);
    step(2'b01, 2'b11, 2'b00, 2'b00);
    step(2'b01, 2'b11, 2'b00, 2'b00);
    step(2'b00, 2'b11, 2'b01, 2'b00);
    step(2'b00, 2'b00, 2'b00, 2'b00);
    step(2'b11, 2'b00, 2'b00, 2'b00);
    chk("gate idle held", int'(o_intr_h), 0);
    chk("gate cnt0 kept", cnt_of(0), 2);
    step(2'b00, 2'b01, 2'b00, 2'b00);
    chk("gate enable raises", int'(o_intr_h), 1);
    step(2'b00, 2'b00, 2'b00, 2'b00);
    step(2'b00, 2'b00, 2'b00, 2'b00);
    chk("gate disable keeps req", int'(o_intr_h), 1);
    step(2'b00, 2'b00, 2'b01, 2'b00);
    chk("gate ack completes", int'(o_intr_h), 0);

    // asynchronous reset mid-handshake
    do_reset();
    for (int i = 0; i < 4; i++) step(2'b01, 2'b11, 2'b00, 2'b00);
    chk("rst pre intr", int'(o_intr_h), 1);
    chk("rst pre cnt0", cnt_of(0), 3);
    #2 rst_n = 0;
    #1;
    chk("async rst intr", int'(o_intr_h), 0);
    chk("async rst cnt", int'(o_pend_cnt), 0);
    chk("async rst ovf", int'(o_ovf), 0);
    i_evt = 0; i_int_ack = 0;
    @(posedge clk); #3 rst_n = 1;
    for (int i = 0; i < 3; i++) step(2'b00, 2'b11, 2'b00, 2'b00);
    chk("post rst no req", int'(o_intr_h), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
